// File: rtl/shift_result_stage.sv
// shift_result_stage: registered 2-entry output FIFO behind the vALU 32-bit shifter
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       upstream handshake; in_ready depends only on occupancy
//   in_result, in_amount    shifter output word and shift amount
//   in_logical, in_right    shifter control bits captured as out_op = {right, logical}
//   out_valid/out_ready     result-bus handshake; out_* held stable while stalled
//   out_result, out_zero, out_neg, out_noshift, out_op   head entry fields
//   result_count            wrapping count of completed output transfers
module shift_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic [4:0]       in_amount,
    input  logic             in_logical,
    input  logic             in_right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_noshift,
    output logic [1:0]       out_op,
    output logic [CNT_W-1:0] result_count
);
    // entry layout: {result, zero, neg, noshift, right, logical}
    localparam logic [36:0] ENTRY_RST = {32'd0, 1'b1, 1'b0, 1'b0, 2'b00};
    logic [36:0] mem [DEPTH];
    logic        rp, wp;
    logic [1:0]  count;
    logic        push, pop;
    assign in_ready  = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign {out_result, out_zero, out_neg, out_noshift, out_op} = mem[rp];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ENTRY_RST;
            rp           <= 1'b0;
            wp           <= 1'b0;
            count        <= 2'd0;
            result_count <= '0;
        end else begin
            // flags are computed once at capture so the head fields are plain register reads
            if (push) begin
                mem[wp] <= {in_result, in_result == 32'd0, in_result[31], in_amount == 5'd0, in_right, in_logical};
                wp      <= ~wp;
            end
            if (pop) begin
                rp           <= ~rp;
                result_count <= result_count + 1'b1;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_shift_result_stage.sv
// tb_shift_result_stage: randomized scoreboard bench for shift_result_stage
module tb_shift_result_stage;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, in_logical = 1'b0, in_right = 1'b0;
    logic [31:0] in_result = '0;
    logic [4:0]  in_amount = '0;
    logic        in_ready, out_valid, out_zero, out_neg, out_noshift;
    logic [31:0] out_result;
    logic [1:0]  out_op;
    logic [15:0] result_count;
    logic        w_in_ready, w_out_valid, w_out_zero, w_out_neg, w_out_noshift;
    logic [31:0] w_out_result;
    logic [1:0]  w_out_op;
    logic [3:0]  w_count;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  a;
        logic        rt;
        logic        lg;
    } txn_t;
    txn_t q[$];
    int pops = 0;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    shift_result_stage dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_amount(in_amount), .in_logical(in_logical), .in_right(in_right),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_neg(out_neg), .out_noshift(out_noshift), .out_op(out_op), .result_count(result_count)
    );

    shift_result_stage #(.CNT_W(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_result(in_result), .in_amount(in_amount), .in_logical(in_logical), .in_right(in_right),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_result(w_out_result), .out_zero(w_out_zero),
        .out_neg(w_out_neg), .out_noshift(w_out_noshift), .out_op(w_out_op), .result_count(w_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: a queue of at most two pending results; refuses pushes when it holds two
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            pops = 0;
        end else begin
            bit   acc, pp;
            txn_t t;
            acc = in_valid && q.size() != 2;
            pp  = q.size() != 0 && out_ready;
            t.r = in_result; t.a = in_amount; t.rt = in_right; t.lg = in_logical;
            if (pp) begin
                void'(q.pop_front());
                pops++;
            end
            if (acc) q.push_back(t);
        end
    end

    always @(negedge clk) begin
        txn_t h;
        chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
            chk("out_result", out_result, h.r);
            chk("out_zero", 32'(out_zero), 32'(h.r == 0));
            chk("out_neg", 32'(out_neg), 32'(h.r[31]));
            chk("out_noshift", 32'(out_noshift), 32'(h.a == 0));
            chk("out_op", 32'(out_op), 32'({h.rt, h.lg}));
        end
        chk("result_count", 32'(result_count), 32'(pops % 65536));
        chk("wrap_count", 32'(w_count), 32'(pops % 16));
    end

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] a,
                         input logic rt, input logic lg, input logic rdy);
        @(negedge clk);
        in_valid = v; in_result = r; in_amount = a; in_right = rt; in_logical = lg; out_ready = rdy;
    endtask

    task automatic drive_rand(input logic rdy);
        logic [31:0] r;
        int          sel;
        sel = int'($urandom_range(0, 7));
        r   = sel == 0 ? 32'd0 : (sel == 1 ? 32'h8000_0000 : $urandom);
        drive(1'b1, r, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_zero", 32'(out_zero), 32'd1);
        chk("rst_result", out_result, 32'd0);
        // single transfer
        drive(1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_neg", 32'(out_neg), 32'd1);
        chk("single_zero", 32'(out_zero), 32'd0);
        chk("single_op", 32'(out_op), 32'd1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        chk("single_cnt", 32'(result_count), 32'd1);
        chk("single_empty", 32'(out_valid), 32'd0);
        // fill and backpressure
        drive(1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_FFFF, 5'd3, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 32'h1234_5678, 5'd7, 1'b1, 1'b1, 1'b0); #1;
        chk("full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h1234_5678, 5'd7, 1'b1, 1'b1, 1'b0); #1;
        chk("full_head", out_result, 32'd0);
        chk("full_zero", 32'(out_zero), 32'd1);
        chk("full_noshift", 32'(out_noshift), 32'd1);
        chk("full_ready2", 32'(in_ready), 32'd0);
        // full with simultaneous push attempt and pop
        drive(1'b1, 32'h1234_5678, 5'd7, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        chk("fp_head", out_result, 32'h0000_FFFF);
        chk("fp_ready", 32'(in_ready), 32'd1);
        chk("fp_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        chk("drain_cnt", 32'(result_count), 32'd3);
        chk("drain_empty", 32'(out_valid), 32'd0);
        // streaming
        for (int i = 0; i < 100; i++) drive_rand(1'b1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        chk("stream_cnt", 32'(result_count), 32'd103);
        chk("stream_empty", 32'(out_valid), 32'd0);
        // asynchronous reset with two entries held
        drive_rand(1'b0);
        drive_rand(1'b0);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd1);
        chk("mid_cnt", 32'(result_count), 32'd0);
        chk("mid_wrap", 32'(w_count), 32'd0);
        chk("mid_zero", 32'(out_zero), 32'd1);
        chk("mid_result", out_result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        // counter wrap on the CNT_W=4 instance
        for (int i = 0; i < 17; i++) drive_rand(1'b1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        chk("wrap_cnt", 32'(w_count), 32'd1);
        chk("main_cnt17", 32'(result_count), 32'd17);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
